// File: rtl/systolic_array_result_drain.sv
// systolic_array_result_drain
// Snapshots the systolic controller's flat PE result bus on each rising edge of
// res_valid and streams the N*N entries out one per valid/ready handshake,
// sign-extended to OUT_W, so the controller can start the next job early.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing buffered; waiting for a res_valid rising edge
// DRAIN | buffer holds a result; presenting entry idx on the out port
module systolic_array_result_drain #(
    parameter int N     = 4,
    parameter int RES_W = 16,
    parameter int OUT_W = 32,
    localparam int NUM   = N * N,
    localparam int IDX_W = $clog2(NUM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   res_valid,
    input  logic [NUM*RES_W-1:0]   pe_results,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    input  logic                   clr_overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    state_t             state_q;
    state_t             state_d;
    logic               res_valid_q;
    logic [RES_W-1:0]   buf_q [NUM];
    logic [IDX_W-1:0]   idx_q;
    logic               done_q;
    logic               overrun_q;

    logic               cap;
    logic               handshake;
    logic               hs_last;
    logic               capture_ok;

    assign cap        = res_valid & ~res_valid_q;
    assign handshake  = (state_q == DRAIN) & out_ready;
    assign hs_last    = handshake & (idx_q == LAST_IDX);
    // A new result is taken only when nothing is left to send after this edge.
    assign capture_ok = cap & ((state_q == IDLE) | hs_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a capture coinciding with the last handshake keeps us in DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cap) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs_last && !cap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: words are presented straight from the buffer while draining.
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        out_idx   = '0;
        out_data  = '0;
        if (state_q == DRAIN) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = (idx_q == LAST_IDX);
            out_idx   = idx_q;
            out_data  = OUT_W'($signed(buf_q[idx_q]));
        end
    end

    // Edge detector history, registered every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= res_valid;
        end
    end

    // Result buffer: loaded only on an accepted capture, otherwise frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM; k++) begin
                buf_q[k] <= '0;
            end
        end else if (capture_ok) begin
            for (int k = 0; k < NUM; k++) begin
                buf_q[k] <= pe_results[k*RES_W +: RES_W];
            end
        end
    end

    // Read index: restart on capture, advance on each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (capture_ok) begin
            idx_q <= '0;
        end else if (handshake) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // Done pulse follows the last-word handshake by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= hs_last;
        end
    end

    // Sticky overrun: a dropped result sets it, and setting beats clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (cap && (state_q == DRAIN) && !hs_last) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_systolic_array_result_drain.sv
// Bench for systolic_array_result_drain: directed sequences plus random traffic,
// all cross-checked every cycle against a queue-based reference model.
module tb_systolic_array_result_drain;

    localparam int N     = 4;
    localparam int RES_W = 16;
    localparam int OUT_W = 32;
    localparam int NUM   = N * N;
    localparam int IDX_W = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 res_valid;
    logic [NUM*RES_W-1:0] pe_results;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic                 overrun;
    logic                 clr_overrun;

    systolic_array_result_drain #(.N(N), .RES_W(RES_W), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .res_valid   (res_valid),
        .pe_results  (pe_results),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the words still owed downstream, in order. A new result
    // is accepted only if nothing remains owed once this edge's handshake is done.
    typedef struct {
        int          idx;
        logic [31:0] data;
    } word_t;

    word_t exp_q[$];
    bit    m_done = 1'b0;
    bit    m_over = 1'b0;
    bit    m_rvq  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_done = 1'b0;
            m_over = 1'b0;
            m_rvq  = 1'b0;
        end else begin
            bit    edge_seen;
            bit    last_pop;
            word_t w;
            edge_seen = res_valid && !m_rvq;
            m_rvq     = res_valid;
            last_pop  = 1'b0;
            if (exp_q.size() > 0 && out_ready) begin
                w        = exp_q.pop_front();
                last_pop = (w.idx == NUM - 1);
            end
            m_done = last_pop;
            if (edge_seen && exp_q.size() != 0) begin
                m_over = 1'b1;
            end else if (clr_overrun) begin
                m_over = 1'b0;
            end
            if (edge_seen && exp_q.size() == 0) begin
                for (int k = 0; k < NUM; k++) begin
                    logic [15:0] e;
                    e      = pe_results[k*RES_W +: RES_W];
                    w.idx  = k;
                    w.data = {{16{e[15]}}, e};
                    exp_q.push_back(w);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit ev;
        ev = (exp_q.size() > 0);
        chk("m_out_valid", 32'(out_valid), 32'(ev));
        chk("m_busy", 32'(busy), 32'(ev));
        chk("m_done", 32'(done), 32'(m_done));
        chk("m_overrun", 32'(overrun), 32'(m_over));
        if (ev) begin
            chk("m_out_data", out_data, exp_q[0].data);
            chk("m_out_idx", 32'(out_idx), 32'(exp_q[0].idx));
            chk("m_out_last", 32'(out_last), 32'(exp_q[0].idx == NUM - 1));
        end else begin
            chk("m_out_last_idle", 32'(out_last), 32'(0));
        end
    endtask

    // Compare against the model at the falling edge, then move 1 time unit on
    // so inputs change well away from either clock edge.
    task automatic tick();
        @(negedge clk);
        check_model();
        #1;
    endtask

    function automatic logic [NUM*RES_W-1:0] ramp(input int base);
        logic [NUM*RES_W-1:0] b;
        for (int k = 0; k < NUM; k++) begin
            b[k*RES_W +: RES_W] = 16'(base + k);
        end
        return b;
    endfunction

    logic [31:0] rx_data [NUM];
    int          rx_order [64];
    int          nwords;
    int          ndone;
    bit          bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Collect handshaken words until a done pulse leaves the block idle.
    task automatic drain(input int maxc, input bit bp);
        nwords = 0;
        ndone  = 0;
        for (int c = 0; c < maxc; c++) begin
            if (bp) out_ready = bp_pat[c % 4];
            if (out_valid && out_ready && nwords < 64) begin
                rx_data[out_idx] = out_data;
                rx_order[nwords] = int'(out_idx);
                nwords++;
            end
            tick();
            if (done) ndone++;
            if (ndone > 0 && !busy) break;
        end
        out_ready = 1'b1;
    endtask

    task automatic check_order(input string name, input int first);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < nwords; i++) begin
            if (rx_order[i] != first + i) ok = 1'b0;
        end
        chk(name, 32'(ok), 32'(1));
    endtask

    task automatic wait_idx(input int k);
        int c;
        c = 0;
        while (!(out_valid && int'(out_idx) == k) && c < 60) begin
            tick();
            c++;
        end
        chk("wait_idx_timeout", 32'(c < 60), 32'(1));
    endtask

    task automatic load(input logic [NUM*RES_W-1:0] bus);
        pe_results = bus;
        res_valid  = 1'b1;
        tick();
        res_valid  = 1'b0;
    endtask

    typedef struct {
        int          k;
        logic [15:0] entry;
        logic [31:0] exp;
    } sx_vec_t;

    sx_vec_t sx_tab [6];

    initial begin
        sx_tab[0] = '{5,  16'hFFF0, 32'hFFFF_FFF0};
        sx_tab[1] = '{6,  16'h7FFF, 32'h0000_7FFF};
        sx_tab[2] = '{0,  16'h8000, 32'hFFFF_8000};
        sx_tab[3] = '{15, 16'h0001, 32'h0000_0001};
        sx_tab[4] = '{3,  16'hFFFF, 32'hFFFF_FFFF};
        sx_tab[5] = '{9,  16'h0000, 32'h0000_0000};

        rst_n       = 1'b0;
        res_valid   = 1'b0;
        pe_results  = '0;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", out_data, 32'(0));
        chk("rst_out_idx", 32'(out_idx), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        rst_n = 1'b1;
        tick();

        // Basic drain with 1-cycle output latency
        out_ready = 1'b1;
        load(ramp(1));
        chk("lat_out_valid", 32'(out_valid), 32'(1));
        chk("lat_out_idx", 32'(out_idx), 32'(0));
        chk("lat_out_data", out_data, 32'(1));
        drain(60, 1'b0);
        chk("basic_nwords", 32'(nwords), 32'(16));
        chk("basic_ndone", 32'(ndone), 32'(1));
        check_order("basic_order", 0);
        for (int k = 0; k < NUM; k++) chk("basic_data", rx_data[k], 32'(k + 1));
        tick();
        chk("basic_busy_after", 32'(busy), 32'(0));

        // Sign extension, table driven
        pe_results = ramp(1);
        for (int i = 0; i < 6; i++) pe_results[sx_tab[i].k*RES_W +: RES_W] = sx_tab[i].entry;
        load(pe_results);
        drain(60, 1'b0);
        for (int i = 0; i < 6; i++) chk("sext", rx_data[sx_tab[i].k], sx_tab[i].exp);

        // Backpressure 1,0,0,1
        load(ramp(100));
        drain(120, 1'b1);
        chk("bp_nwords", 32'(nwords), 32'(16));
        chk("bp_ndone", 32'(ndone), 32'(1));
        check_order("bp_order", 0);
        for (int k = 0; k < NUM; k++) chk("bp_data", rx_data[k], 32'(100 + k));

        // Overrun: new edge mid-drain is dropped
        load(ramp(200));
        wait_idx(7);
        pe_results = ramp(500);
        res_valid  = 1'b1;
        tick();
        res_valid  = 1'b0;
        chk("ovr_set", 32'(overrun), 32'(1));
        drain(60, 1'b0);
        chk("ovr_nwords", 32'(nwords), 32'(8));
        check_order("ovr_order", 8);
        for (int k = 8; k < NUM; k++) chk("ovr_data", rx_data[k], 32'(200 + k));
        repeat (3) tick();
        chk("ovr_sticky", 32'(overrun), 32'(1));
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'(0));
        load(ramp(300));
        tick();
        res_valid   = 1'b1;
        clr_overrun = 1'b1;
        tick();
        res_valid   = 1'b0;
        clr_overrun = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'(1));
        drain(60, 1'b0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;

        // Back-to-back capture on the last handshake
        load(ramp(600));
        wait_idx(15);
        pe_results = ramp(700);
        pe_results[RES_W-1:0] = 16'hFFFE;
        res_valid  = 1'b1;
        tick();
        res_valid  = 1'b0;
        chk("b2b_out_valid", 32'(out_valid), 32'(1));
        chk("b2b_out_idx", 32'(out_idx), 32'(0));
        chk("b2b_out_data", out_data, 32'hFFFF_FFFE);
        chk("b2b_done", 32'(done), 32'(1));
        chk("b2b_overrun", 32'(overrun), 32'(0));
        drain(60, 1'b0);
        chk("b2b_nwords", 32'(nwords), 32'(16));
        for (int k = 1; k < NUM; k++) chk("b2b_data", rx_data[k], 32'(700 + k));

        // Reset mid-drain, res_valid held through reset release
        load(ramp(800));
        wait_idx(9);
        #1;
        rst_n     = 1'b0;
        res_valid = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'(0));
        chk("arst_out_data", out_data, 32'(0));
        chk("arst_out_idx", 32'(out_idx), 32'(0));
        chk("arst_out_last", 32'(out_last), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rel_out_valid", 32'(out_valid), 32'(1));
        chk("rel_out_idx", 32'(out_idx), 32'(0));
        chk("rel_out_data", out_data, 32'(800));
        res_valid = 1'b0;
        drain(60, 1'b0);
        chk("rel_nwords", 32'(nwords), 32'(16));

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) res_valid = ~res_valid;
            out_ready   = ($urandom_range(0, 3) != 0);
            clr_overrun = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int w = 0; w < NUM * RES_W / 32; w++) pe_results[w*32 +: 32] = $urandom;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
